// File: rtl/mm_timer_pkg.sv
// Shared register map, bit positions and FSM encoding
// for the memory-mapped down-counter timer.
package mm_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;

  localparam int STAT_EXP = 0;
  localparam int STAT_RUN = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mm_timer_prescaler.sv
// Divides clk by (pre+1) while running; tick is high
// in the cycle whose edge should advance COUNT.
module mm_timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = run && (pre_cnt == pre);

  always_ff @(posedge clk) begin
    if (rst || restart || !run || tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + PRE_W'(1);
  end

endmodule

// File: rtl/mm_timer.sv
// Programmable down-counter timer slave: CTRL/LOAD/
// COUNT/STATUS registers, one-shot or auto-reload.
module mm_timer
  import mm_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Done
);

  state_t           state;
  logic             en;
  logic             auto_rl;
  logic             ie;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] count;
  logic             exp;
  logic             tick;
  logic             running;
  logic             ctrl_wr;
  logic             start;
  logic             stop;
  logic             expire;
  logic             reload;
  logic             oneshot;
  logic             dec;
  logic             w1c;
  logic             unused_wd;

  assign unused_wd = ^WD;
  assign running   = (state == RUN);
  assign ctrl_wr   = WE && (A == REG_CTRL);
  assign start     = ctrl_wr && WD[CTRL_EN];
  assign stop      = ctrl_wr && !WD[CTRL_EN];
  assign w1c       = WE && (A == REG_STATUS)
                     && WD[STAT_EXP];

  // A CTRL write on the same edge overrides any tick.
  assign expire  = running && tick && !ctrl_wr
                   && (count == '0);
  assign reload  = expire && auto_rl;
  assign oneshot = expire && !auto_rl;
  assign dec     = running && tick && !ctrl_wr
                   && (count != '0);

  mm_timer_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (running),
    .restart(start),
    .pre    (pre),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      pre     <= '0;
      load    <= '0;
      count   <= '0;
      exp     <= 1'b0;
    end else begin
      if (WE && (A == REG_LOAD))
        load <= WD[CNT_W-1:0];
      if (ctrl_wr) begin
        en      <= WD[CTRL_EN];
        auto_rl <= WD[CTRL_AUTO];
        ie      <= WD[CTRL_IE];
        pre     <= WD[CTRL_PRE_LSB +: PRE_W];
      end
      unique case (1'b1)
        start: begin
          state <= RUN;
          count <= load;
        end
        stop:    state <= IDLE;
        reload:  count <= load;
        oneshot: begin
          state <= IDLE;
          en    <= 1'b0;
        end
        dec:     count <= count - CNT_W'(1);
        default: ;
      endcase
      // Expiry beats a simultaneous W1C so no event is lost.
      if (expire)
        exp <= 1'b1;
      else if (w1c)
        exp <= 1'b0;
    end
  end

  always_comb begin
    RD = '0;
    unique case (A)
      REG_CTRL: begin
        RD[CTRL_EN]   = en;
        RD[CTRL_AUTO] = auto_rl;
        RD[CTRL_IE]   = ie;
        RD[CTRL_PRE_LSB +: PRE_W] = pre;
      end
      REG_LOAD:  RD = 32'(load);
      REG_COUNT: RD = 32'(count);
      REG_STATUS: begin
        RD[STAT_EXP] = exp;
        RD[STAT_RUN] = running;
      end
    endcase
  end

  assign Done = exp & ie;

endmodule
